// File: rtl/qpp_deinterleave_buffer_pkg.sv
// Shared definitions for the QPP interleaver path: block-size limits,
// lane geometry, FSM encoding and small helper functions.
package qpp_deinterleave_buffer_pkg;

    localparam int LANES  = 8;
    localparam int ADDR_W = 13;
    localparam int ROW_W  = 10;

    localparam logic [ADDR_W-1:0] K_MIN = 13'd1024;
    localparam logic [ADDR_W-1:0] K_MAX = 13'd6144;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // K must be a multiple of 32 inside [K_MIN, K_MAX].
    function automatic logic k_is_valid(input logic [ADDR_W-1:0] k);
        return (k[4:0] == 5'd0) && (k >= K_MIN) && (k <= K_MAX);
    endfunction

    // Natural-index offset of a lane inside a beat: (lane>>1)*K/4 + (lane&1).
    function automatic logic [ADDR_W-1:0] lane_nat_offset(input logic [2:0]        lane,
                                                          input logic [ADDR_W-1:0] k);
        logic [ADDR_W-1:0] q;
        logic [ADDR_W-1:0] base;
        q = k >> 2;
        case (lane[2:1])
            2'd0:    base = '0;
            2'd1:    base = q;
            2'd2:    base = q << 1;
            default: base = (q << 1) + q;
        endcase
        return base + {{(ADDR_W-1){1'b0}}, lane[0]};
    endfunction

endpackage

// File: rtl/qpp_deinterleave_buffer_bank_map.sv
// Combinational address-to-bank mapping. The address space is cut into
// four quarters of Q = K/4; the quarter index and the offset parity pick
// one of eight banks, the offset divided by two is the row.
module qpp_bank_map import qpp_deinterleave_buffer_pkg::*; (
    input  logic [ADDR_W-1:0] i_a,
    input  logic [ADDR_W-1:0] i_k,
    output logic [2:0]        o_bank,
    output logic [ROW_W-1:0]  o_row,
    output logic              o_oor
);

    logic [ADDR_W-1:0] w_q;
    logic [ADDR_W:0]   w_q2;
    logic [ADDR_W:0]   w_q3;
    logic              w_ge1;
    logic              w_ge2;
    logic              w_ge3;
    logic [1:0]        w_s;
    logic [10:0]       w_base;
    logic [10:0]       w_o;

    assign w_q   = i_k >> 2;
    assign w_q2  = {w_q, 1'b0};
    assign w_q3  = w_q2 + {1'b0, w_q};
    assign w_ge1 = i_a >= w_q;
    assign w_ge2 = {1'b0, i_a} >= w_q2;
    assign w_ge3 = {1'b0, i_a} >= w_q3;

    // Quarter select and quarter base; offsets are below 1536 so 11 bits suffice.
    always_comb begin
        w_s    = 2'd0;
        w_base = '0;
        if (w_ge3) begin
            w_s    = 2'd3;
            w_base = w_q3[10:0];
        end else if (w_ge2) begin
            w_s    = 2'd2;
            w_base = w_q2[10:0];
        end else if (w_ge1) begin
            w_s    = 2'd1;
            w_base = w_q[10:0];
        end
    end

    assign w_o    = i_a[10:0] - w_base;
    assign o_bank = {w_s, w_o[0]};
    assign o_row  = w_o[10:1];
    assign o_oor  = i_a >= i_k;

endmodule

// File: rtl/qpp_deinterleave_buffer.sv
// Deinterleaving buffer: scatters eight interleaved soft values per beat
// into eight banks, then drains the frame in natural order, eight per beat.
module qpp_deinterleave_buffer import qpp_deinterleave_buffer_pkg::*; #(
    parameter int W    = 8,
    parameter int KMAX = 6144
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       K,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*ADDR_W-1:0] in_addr,
    input  logic [LANES*W-1:0]      in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*W-1:0]      out_data,
    output logic [ROW_W-1:0]        out_row,
    output logic                    done,
    output logic                    err
);

    localparam int DEPTH = KMAX / LANES;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_k;
    logic [ROW_W-1:0]    w_r;
    logic [ROW_W-1:0]    r_in_cnt;
    logic                r_flush_cnt;
    logic [ROW_W-1:0]    r_rd_row;
    logic                r_err;
    logic                r_done;
    logic                r_out_valid;
    logic [ROW_W-1:0]    r_out_row;
    logic [LANES*W-1:0]  r_out_data;
    logic                w_busy;
    logic                w_in_ready;

    logic                w_start_ok;
    logic                w_in_fire;
    logic                w_last_in;
    logic                w_out_fire;
    logic                w_last_out;
    logic                w_rd_issue;
    logic                w_beat_err;

    logic [2:0]          w_lane_bank [LANES];
    logic [ROW_W-1:0]    w_lane_row  [LANES];
    logic [LANES-1:0]    w_lane_oor;

    logic [LANES-1:0]    w_bank_we;
    logic [ROW_W-1:0]    w_bank_row  [LANES];
    logic [W-1:0]        w_bank_data [LANES];
    logic                w_coll;

    logic [LANES-1:0]    r_wr_en_p1;
    logic [ROW_W-1:0]    r_wr_row_p1  [LANES];
    logic [W-1:0]        r_wr_data_p1 [LANES];

    logic [W-1:0]        r_mem [LANES][DEPTH];

    assign w_r        = r_k[ADDR_W-1:3];
    assign w_start_ok = start && k_is_valid(K);
    assign w_in_fire  = in_valid && (r_state == ST_FILL);
    assign w_last_in  = w_in_fire && (r_in_cnt == w_r - 10'd1);
    assign w_out_fire = r_out_valid && out_ready;
    assign w_last_out = (r_state == ST_DRAIN) && w_out_fire && (r_out_row == w_r - 10'd1);
    assign w_rd_issue = (r_state == ST_DRAIN) && (!r_out_valid || out_ready) && (r_rd_row < w_r);
    assign w_beat_err = (|w_lane_oor) || w_coll;

    for (genvar g = 0; g < LANES; g++) begin : g_map
        qpp_bank_map u_map (
            .i_a    (in_addr[g*ADDR_W +: ADDR_W]),
            .i_k    (r_k),
            .o_bank (w_lane_bank[g]),
            .o_row  (w_lane_row[g]),
            .o_oor  (w_lane_oor[g])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        w_next     = r_state;
        w_busy     = 1'b1;
        w_in_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_start_ok) w_next = ST_FILL;
            end
            ST_FILL: begin
                w_in_ready = 1'b1;
                if (w_last_in) w_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (r_flush_cnt) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_last_out) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Frame counters, latched block size and the sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k         <= '0;
            r_in_cnt    <= '0;
            r_flush_cnt <= 1'b0;
            r_rd_row    <= '0;
            r_err       <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && w_start_ok) begin
                r_k      <= K;
                r_in_cnt <= '0;
                r_rd_row <= '0;
            end
            if (w_in_fire) r_in_cnt <= r_in_cnt + 10'd1;
            r_flush_cnt <= (r_state == ST_FLUSH) ? !r_flush_cnt : 1'b0;
            if (w_rd_issue) r_rd_row <= r_rd_row + 10'd1;
            if ((r_state == ST_IDLE) && start) r_err <= !w_start_ok;
            else if (w_in_fire && w_beat_err)  r_err <= 1'b1;
        end
    end

    // Scatter lanes onto banks; on a bank clash the later (higher) lane wins.
    always_comb begin
        w_bank_we = '0;
        w_coll    = 1'b0;
        for (int b = 0; b < LANES; b++) begin
            w_bank_row[b]  = '0;
            w_bank_data[b] = '0;
        end
        for (int l = 0; l < LANES; l++) begin
            if (!w_lane_oor[l]) begin
                if (w_bank_we[w_lane_bank[l]]) w_coll = 1'b1;
                w_bank_we[w_lane_bank[l]]   = 1'b1;
                w_bank_row[w_lane_bank[l]]  = w_lane_row[l];
                w_bank_data[w_lane_bank[l]] = in_data[l*W +: W];
            end
        end
    end

    // ---- write stage p1: registered per-bank write enables ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wr_en_p1 <= '0;
        else     r_wr_en_p1 <= w_in_fire ? w_bank_we : '0;
    end

    // Registered per-bank write row and data (no reset on the datapath).
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            for (int b = 0; b < LANES; b++) begin
                r_wr_row_p1[b]  <= w_bank_row[b];
                r_wr_data_p1[b] <= w_bank_data[b];
            end
        end
    end

    // ---- write stage p2: bank write ----
    always_ff @(posedge clk) begin
        for (int b = 0; b < LANES; b++) begin
            if (r_wr_en_p1[b]) r_mem[b][r_wr_row_p1[b]] <= r_wr_data_p1[b];
        end
    end

    // Read port: natural lane l always lives in bank l at row m.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_last_out;
            if (w_rd_issue) begin
                r_out_valid <= 1'b1;
                r_out_row   <= r_rd_row;
                for (int l = 0; l < LANES; l++) r_out_data[l*W +: W] <= r_mem[l][r_rd_row];
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign busy      = w_busy;
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_row   = r_out_row;
    assign out_data  = r_out_data;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_qpp_deinterleave_buffer.sv
// Directed bench for qpp_deinterleave_buffer: a table of frame records
// plus hand-written sequences for invalid K and reset during drain.
module tb_qpp_deinterleave_buffer;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [12:0]   K;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [103:0]  in_addr;
    logic [63:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [9:0]    out_row;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_err    = 0;
    int cyc_now  = 0;

    logic [7:0] y [6144];

    typedef struct {
        int k;
        int f1;
        int f2;
        int pct;
        bit bubbles;
        bit collide;
        bit exp_err;
    } vec_t;

    vec_t vecs [4];

    qpp_deinterleave_buffer #(.W(8), .KMAX(6144)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .K         (K),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int qpp(input int i, input int k, input int f1, input int f2);
        longint li;
        li = i;
        return int'((f1 * li + f2 * li * li) % k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v, input int rst_at);
        int         r, q, n, guard, exp_row, done_cnt, t0, t_done;
        bit         take, rdy, stalled;
        logic [103:0] a;
        logic [63:0]  d, exp_d, prev_d;
        logic [9:0]   prev_row;
        r = v.k / 8;
        q = v.k / 4;
        K = v.k[12:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc_now;
        check("start_busy", busy, 1);
        check("start_err", err, 0);

        n = 0;
        guard = 0;
        while (n < r && guard < 4 * r + 20) begin
            take = in_ready && !(v.bubbles && (guard % 7 == 3));
            if (take) begin
                for (int l = 0; l < 8; l++) begin
                    int idx, ad;
                    idx = 2 * n + (l >> 1) * q + (l & 1);
                    ad  = qpp(idx, v.k, v.f1, v.f2);
                    if (v.collide && n == r - 1 && (l == 2 || l == 5)) ad = 5;
                    a[13*l +: 13] = ad[12:0];
                    d[8*l +: 8]   = idx[7:0];
                    y[ad] = idx[7:0];
                end
                in_addr  = a;
                in_data  = d;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (take) n++;
            guard++;
        end
        check("fill_beats", n, r);
        check("ready_after_fill", in_ready, 0);

        // Junk beats held while not ready must be ignored.
        in_valid = 1'b1;
        in_addr  = '0;
        in_data  = '1;

        exp_row  = 0;
        done_cnt = 0;
        guard    = 0;
        stalled  = 1'b0;
        t_done   = -1;
        prev_d   = '0;
        prev_row = '0;
        while (guard < 6 * r + 50 && !(exp_row == r && done_cnt > 0)) begin
            if (stalled) check("hold", {out_valid, out_row, out_data}, {1'b1, prev_row, prev_d});
            if (done) begin
                done_cnt++;
                t_done = cyc_now;
                check("done_busy", busy, 0);
            end
            rdy = (v.pct >= 100) || ($urandom_range(0, 99) < v.pct);
            out_ready = rdy;
            stalled  = out_valid && !rdy;
            prev_d   = out_data;
            prev_row = out_row;
            if (out_valid && rdy) begin
                for (int l = 0; l < 8; l++) exp_d[8*l +: 8] = y[2 * exp_row + (l >> 1) * q + (l & 1)];
                check("row_idx", out_row, exp_row);
                check("row_data", out_data, exp_d);
                exp_row++;
                if (rst_at >= 0 && exp_row == rst_at) begin
                    rst = 1'b1;
                    #1;
                    check("rst_busy", busy, 0);
                    check("rst_out_valid", out_valid, 0);
                    check("rst_out_data", out_data, 0);
                    in_valid  = 1'b0;
                    out_ready = 1'b0;
                    tick();
                    rst = 1'b0;
                    tick();
                    return;
                end
            end
            tick();
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check("rows_out", exp_row, r);
        check("done_once", done_cnt, 1);
        check("frame_err", err, v.exp_err);
        check("idle_busy", busy, 0);
        if (v.pct >= 100 && !v.bubbles) check("frame_len", t_done - t0, 2 * r + 3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{k: 1024, f1: 1,   f2: 0,   pct: 100, bubbles: 0, collide: 0, exp_err: 0};
        vecs[1] = '{k: 1024, f1: 1,   f2: 0,   pct: 100, bubbles: 0, collide: 1, exp_err: 1};
        vecs[2] = '{k: 1024, f1: 31,  f2: 64,  pct: 70,  bubbles: 1, collide: 0, exp_err: 0};
        vecs[3] = '{k: 6144, f1: 263, f2: 480, pct: 50,  bubbles: 0, collide: 0, exp_err: 0};

        rst       = 1'b1;
        start     = 1'b0;
        K         = '0;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_busy0", busy, 0);
        check("rst_in_ready0", in_ready, 0);
        check("rst_out_valid0", out_valid, 0);
        check("rst_out_data0", out_data, 0);
        check("rst_out_row0", out_row, 0);
        check("rst_done0", done, 0);
        check("rst_err0", err, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) run_frame(vecs[i], -1);

        // Invalid block sizes: err set, FSM stays idle.
        K = 13'd1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("badk1000_err", err, 1);
        check("badk1000_busy", busy, 0);
        tick();
        check("badk1000_idle", busy, 0);
        K = 13'd6176;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("badk6176_err", err, 1);
        check("badk6176_busy", busy, 0);
        tick();

        // A valid start clears err (checked inside) and the frame completes.
        run_frame(vecs[0], -1);

        // Reset during drain, then a fresh frame.
        run_frame(vecs[0], 40);
        check("post_rst_busy", busy, 0);
        check("post_rst_err", err, 0);
        run_frame(vecs[2], -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/qpp_deinterleave_buffer.md
# qpp_deinterleave_buffer

Deinterleaving buffer for the QPP turbo interleaver path. Each beat accepts the eight interleaved addresses and eight natural-order soft values from the interleaver pipeline and scatters each value to its address. Once all K values are stored, the block drains the frame in natural order, eight values per beat, in the same lane layout. It sits downstream of the QPP interleaver address generator and upstream of the SISO decoder input.

## Interface
Parameters:
- `W`, 8, soft-value width.
- `KMAX`, 6144, largest supported block size. Bank depth is KMAX/8 = 768.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that latches `K`. Honoured only in IDLE.
- `K` in 13: block size. Valid only if it is a multiple of 32 and 1024 ≤ K ≤ 6144.
- `busy` out 1: high whenever the state is not IDLE.
- `in_valid` in 1: an input beat is present.
- `in_ready` out 1: high only in FILL.
- `in_addr` in 104: eight 13-bit lanes, lane l at bits [13l+12:13l]. Lane order is Pi(2n), Pi(2n+1), Pi(2n+K/4), Pi(2n+K/4+1), Pi(2n+K/2), Pi(2n+K/2+1), Pi(2n+3K/4), Pi(2n+3K/4+1).
- `in_data` in 8·W: data lane l belongs to address lane l.
- `out_valid` in/out: out 1.
- `out_ready` in 1.
- `out_data` out 8·W: lane l holds natural index 2m + (l>>1)·K/4 + (l&1).
- `out_row` out 10: row index m of the current output beat.
- `done` out 1: one-cycle pulse after the last output beat is accepted.
- `err` out 1: sticky error flag, cleared by `start` or `rst`.

## Operation
- Derived values: Q = K/4 and R = K/8, the beat count.
- Bank mapping for address a:
  - s = a≥3Q ? 3 : a≥2Q ? 2 : a≥Q ? 1 : 0.
  - o = a − s·Q.
  - bank = {s, o[0]}.
  - row = o>>1.
  - Use comparators and subtractors only, no divider.
  - For a legal QPP with f1 odd and f2 even, the eight lanes of one beat hit eight distinct banks.
- FSM states: IDLE → FILL → FLUSH → DRAIN → IDLE.
- IDLE:
  - On `start` with a valid K: latch K, clear `err`, clear the counters, go to FILL.
  - On `start` with an invalid K: set `err`, stay in IDLE.
- FILL:
  - Each handshake (`in_valid`&`in_ready`) is one beat.
  - After beat R is accepted, go to FLUSH.
- FLUSH: wait 2 cycles for the write pipeline to empty, then go to DRAIN.
- DRAIN:
  - Issue a read of row r to all 8 banks when (!`out_valid` | `out_ready`) and r < R.
  - When the last beat is accepted, pulse `done` and return to IDLE.
- Error conditions (all set `err`):
  - A lane address ≥ K: that lane's write is suppressed.
  - Two lanes of one beat map to the same bank: the higher-numbered lane wins.
- `start` is ignored outside IDLE.
- Memory contents are not reset. Every location read in DRAIN has been written in FILL when the address stream is a legal permutation.

## Timing
- Reset values: state IDLE, all counters 0, `in_ready` 0, `busy` 0, `out_valid` 0, `out_data` 0, `out_row` 0, `done` 0, `err` 0.
- Write pipeline:
  - Beat accepted at cycle t.
  - Bank/row/data registered at t+1.
  - Bank write at t+2.
- Read latency: a read issued at cycle t gives `out_valid` with data at t+1.
  - `out_data` and `out_row` hold stable while `out_valid` is high and `out_ready` is low.
- Minimum frame time with no stalls: 1 (start) + R + 2 + R + 1 cycles.
- `in_ready` falls in the cycle after the R-th beat. `in_valid` while `in_ready` is low is ignored.
- Reset mid-frame returns to IDLE immediately. The next frame needs a fresh `start`.

## Structure
- Shared package, used by the interleaver and this block:
  - Constants: KMIN=1024, KMAX=6144, lane count 8, address width 13, row width 10.
  - A function for K validity.
  - A function for lane-to-offset mapping.
- One sub-module, `qpp_bank_map`: combinational, (a, K) → (bank, row, out_of_range). Instantiated 8 times.
- Banks are 8 register arrays of 768×W, each with one write port and one read port.

## Test plan
- K=1024, identity addresses (Pi(i)=i), data = i mod 256 → 128 output beats; lane l of row m equals (2m + (l>>1)·256 + (l&1)) mod 256; `err`=0; `done` pulses once.
- K=1024, QPP f1=31, f2=64, data = i mod 256 → output lane value equals deinterleaved input (y[Pi(i)] = x[i]); `err`=0.
- K=6144, QPP f1=263, f2=480 with random `out_ready` (50%) → no lost or duplicated rows; `out_row` runs 0..767 in order.
- Beat with two lanes at address 5 → `err`=1; bank row holds the higher lane's data; frame still completes.
- `start` with K=1000, then with K=6176 → `err`=1, `busy` stays 0; later valid `start` clears `err`.
- Assert `rst` at beat 40 of DRAIN → next cycle `busy`=0, `out_valid`=0; new frame with K=1024 completes correctly.
